// File: rtl/_pipelined_tree_decoder.sv
// Pipelined one-hot tree decoder with valid/ready backpressure and out-of-range flagging.
// Define TREE_DECODER_HOLD_EN to keep out/out_error at their last values while out_valid is low.
module _pipelined_tree_decoder #(
    parameter int output_width   = 8,
    parameter int pipeline_depth = 2,
    localparam int sel_width     = $clog2((output_width > 1) ? output_width : 2)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [sel_width-1:0]    select,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [output_width-1:0] out,
    output logic                    out_error
);

    localparam int full_width = 1 << sel_width;
    localparam int mid_stages = (pipeline_depth > 1) ? pipeline_depth - 1 : 1;
    localparam int base_bits  = sel_width / pipeline_depth;
    localparam int extra_bits = sel_width % pipeline_depth;
    localparam logic [sel_width:0] width_limit = (sel_width + 1)'(output_width);

    // Earlier stages take the leftover select bits.
    function automatic int chunk_bits(input int k);
        return base_bits + ((k < extra_bits) ? 1 : 0);
    endfunction

    function automatic int cum_bits(input int k);
        int sum;
        sum = 0;
        for (int i = 0; i <= k; i++) begin
            sum = sum + chunk_bits(i);
        end
        return sum;
    endfunction

    // Each line of the partial one-hot fans out into 2**c lines, one per chunk value.
    function automatic logic [full_width-1:0] expand(input logic [full_width-1:0] part,
                                                      input int c,
                                                      input logic [sel_width-1:0] chunk);
        logic [full_width-1:0] nxt;
        nxt = '0;
        for (int n = 0; n < full_width; n++) begin
            nxt[n] = part[sel_width'(n >> c)] & ((n % (1 << c)) == int'(chunk));
        end
        return nxt;
    endfunction

    logic [pipeline_depth-1:0] vld_s;
    logic [pipeline_depth-1:0] adv_s;

    logic                  mid_vld_r  [mid_stages];
    logic [full_width-1:0] mid_part_r [mid_stages];
    logic [sel_width-1:0]  mid_sel_r  [mid_stages];
    logic                  mid_en_r   [mid_stages];
    logic                  mid_oor_r  [mid_stages];

    logic                    last_vld_r;
    logic [output_width-1:0] out_r;
    logic                    err_r;

    // Advance chain: a stage moves when it is empty or everything downstream moves.
    always_comb begin
        adv_s = '0;
        adv_s[pipeline_depth-1] = ~vld_s[pipeline_depth-1] | out_ready;
        for (int k = pipeline_depth - 2; k >= 0; k--) begin
            adv_s[k] = ~vld_s[k] | adv_s[k+1];
        end
    end

    for (genvar k = 0; k < pipeline_depth; k++) begin : g_stage
        localparam int c_bits = chunk_bits(k);
        localparam int shift  = sel_width - cum_bits(k);

        logic                  src_vld_s;
        logic                  src_en_s;
        logic                  src_oor_s;
        logic [full_width-1:0] src_part_s;
        logic [full_width-1:0] next_part_s;
        logic [sel_width-1:0]  src_sel_s;
        logic [sel_width-1:0]  chunk_s;

        if (k == 0) begin : g_src_in
            assign src_vld_s  = in_valid;
            assign src_en_s   = enable;
            assign src_sel_s  = select;
            assign src_part_s = full_width'(1);
            assign src_oor_s  = {1'b0, select} >= width_limit;
        end else begin : g_src_mid
            assign src_vld_s  = mid_vld_r[k-1];
            assign src_en_s   = mid_en_r[k-1];
            assign src_sel_s  = mid_sel_r[k-1];
            assign src_part_s = mid_part_r[k-1];
            assign src_oor_s  = mid_oor_r[k-1];
        end

        assign chunk_s     = (src_sel_s >> shift) & sel_width'((1 << c_bits) - 1);
        assign next_part_s = expand(src_part_s, c_bits, chunk_s);

        if (k < pipeline_depth - 1) begin : g_mid
            assign vld_s[k] = mid_vld_r[k];

            // Intermediate stage register: partial one-hot plus the select carried forward.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mid_vld_r[k]  <= 1'b0;
                    mid_part_r[k] <= '0;
                    mid_sel_r[k]  <= '0;
                    mid_en_r[k]   <= 1'b0;
                    mid_oor_r[k]  <= 1'b0;
                end else if (adv_s[k]) begin
                    mid_vld_r[k]  <= src_vld_s;
                    mid_part_r[k] <= next_part_s;
                    mid_sel_r[k]  <= src_sel_s;
                    mid_en_r[k]   <= src_en_s;
                    mid_oor_r[k]  <= src_oor_s;
                end
            end
        end else begin : g_last
            assign vld_s[k] = last_vld_r;

            // Output stage: final decode, enable masking and error flag land directly in the output registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    last_vld_r <= 1'b0;
                    out_r      <= '0;
                    err_r      <= 1'b0;
                end else if (adv_s[k]) begin
                    last_vld_r <= src_vld_s;
                    if (src_vld_s) begin
                        out_r <= src_en_s ? next_part_s[output_width-1:0] : '0;
                        err_r <= src_en_s & src_oor_s;
                    end else begin
`ifdef TREE_DECODER_HOLD_EN
                        out_r <= out_r;
                        err_r <= err_r;
`else
                        out_r <= '0;
                        err_r <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = last_vld_r;
    assign out       = out_r;
    assign out_error = err_r;

endmodule

// File: doc/_pipelined_tree_decoder.md
Name: _pipelined_tree_decoder

Overview:
Registered, pipelined successor to the combinational tree decoder. It converts a binary select into a one-hot output word over a configurable number of pipeline stages, with a valid/ready stream handshake and backpressure. It flags out-of-range selects when output_width is not a power of two. It sits in front of wide enable/strobe fan-outs where the combinational decoder limits timing.

Parameters:
output_width, 8, number of one-hot output lines; must be >= 1.
pipeline_depth, 2, number of register stages from input to output; legal range 1 .. $clog2(`max(output_width, 2)).

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
enable  input  1  per-transaction enable; captured with select.
in_valid  input  1  select/enable valid this cycle.
in_ready  output  1  block accepts a transaction this cycle.
select  input  $clog2(`max(output_width, 2))  binary index.
out_valid  output  1  out/out_error hold a completed transaction.
out_ready  input  1  downstream accepts the output this cycle.
out  output  output_width  one-hot decode result.
out_error  output  1  select >= output_width for this transaction.

Behaviour:
- One clock domain. Reset is synchronous and active-low: it is sampled only on the rising clk edge while rst_n == 0.
- Reset values:
  - every stage valid bit = 0
  - out_valid = 0
  - out = 0
  - out_error = 0
  - in_ready = 1 from the first cycle after reset releases.
- Handshake:
  - A transaction is accepted when in_valid && in_ready.
  - It is consumed when out_valid && out_ready.
  - Ordering is strictly FIFO with no drops or duplicates.
- Latency:
  - An accepted transaction appears on out exactly pipeline_depth cycles later, provided no stall occurs.
  - Throughput is 1 transaction per cycle when out_ready stays high.
- Stall:
  - Each stage has its own valid bit.
  - Stage k advances when it is empty or stage k+1 advances; the last stage advances on out_ready.
  - in_ready = stage-0 empty OR stage 0 advances. It is combinational from out_ready through the valid chain; no skid buffer.
  - Capacity is pipeline_depth transactions in flight.
  - While out_valid && !out_ready, out and out_error stay stable.
- Tree decode:
  - The select bits are split across stages, MSB chunk first, as evenly as possible; earlier stages take the extra bits.
  - Each stage expands the partial one-hot by its chunk.
  - The final width is truncated to output_width.
  - The result must equal (1 << select) & {output_width{1'b1}}.
- Out of range (select >= output_width, only possible when output_width is not a power of two):
  - out = 0, out_error = 1.
  - The transaction still flows through and is consumed normally.
- enable = 0 on an accepted transaction:
  - out = 0, out_error = 0, out_valid still asserted.
  - enable has priority over the range check.
- output_width == 1: select is 1 bit; select 1 is out of range.
- Simultaneous accept and consume on a full pipeline is allowed; occupancy is unchanged.
- Reset mid-operation flushes all in-flight transactions. There is no output of partial results.

Optional Feature:
TREE_DECODER_HOLD_EN
- Defined: out and out_error keep their last consumed values while out_valid == 0; they change only when a new transaction reaches the last stage.
- Undefined: out and out_error are forced to 0 whenever out_valid == 0.
- Reset clears them to 0 in both builds.

Test Plan:
1. Reset (output_width=8, pipeline_depth=2). Hold rst_n=0 for 3 cycles, then release -> out_valid=0, out=8'b0, out_error=0, in_ready=1.
2. Streaming. Stream select 0..7, in_valid=1, enable=1, out_ready=1 -> out_valid rises 2 cycles after the first accept; out = 00000001, 00000010, ... 10000000 on consecutive cycles; out_error=0.
3. Backpressure. Drop out_ready=0 after select=3 reaches the output while streaming 3,4,5 -> in_ready=0 once 2 transactions are held; out stays 00001000. Raise out_ready -> 00010000 then 00100000, in order, none lost.
4. Out of range (output_width=5, pipeline_depth=3). select=6 -> out=5'b0, out_error=1, 3 cycles after accept. Then select=4 -> out=10000, out_error=0.
5. Disabled transaction. enable=0 with select=3 -> out=0, out_valid=1, out_error=0. Run under both TREE_DECODER_HOLD_EN settings; with the macro defined, the idle cycle afterward keeps the prior out.
6. Reset mid-stream. Assert rst_n=0 for one cycle with 2 transactions in flight -> the next cycle shows out_valid=0 and out=0; the held transactions never appear.
